// File: rtl/can_rec_msg_fifo.sv
// Assembles CAN receive-register words into 76-bit messages and queues them in a
// first-word-fall-through FIFO drained by a valid/ready handshake.
module can_rec_msg_fifo #(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned BUS_ID_W = 5,
    parameter int unsigned CNT_W    = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [4:0]              addr,
    input  logic [15:0]             data_rec_in,
    input  logic [BUS_ID_W-1:0]     can_rec_select,
    input  logic                    debug_mode,
    output logic                    msg_valid,
    input  logic                    msg_ready,
    output logic [75:0]             msg_data,
    output logic [$clog2(DEPTH):0]  fifo_level,
    output logic                    fifo_full,
    output logic [CNT_W-1:0]        ovf_cnt,
    output logic                    ovf_pulse,
    output logic                    frame_err
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned LvlW = PtrW + 1;

    // Frame assembly state
    logic [10:0] id_q;
    logic [7:0]  b1_q, b2_q, b3_q, b4_q, b5_q, b6_q, b7_q, b8_q;
    logic        open_q;

    // Queue state
    logic [75:0]      mem_q [DEPTH];
    logic [PtrW-1:0]  rd_ptr_q, wr_ptr_q;
    logic [LvlW-1:0]  level_q, level_d;
    logic [CNT_W-1:0] ovf_cnt_q;
    logic             ovf_pulse_q, frame_err_q;

    logic        is_close, is_orphan;
    logic [7:0]  b8_new;
    logic [75:0] push_msg;
    logic        fifo_empty, full, pop, push, drop;

    always_comb begin
        is_close  = wr_en && (addr == 5'd0) && open_q;
        is_orphan = wr_en && (addr == 5'd0) && !open_q;
        b8_new    = debug_mode ? data_rec_in[7:0] : 8'(can_rec_select);
        // Closing word's own bytes bypass the assembly registers so the push happens now
        push_msg  = {1'b0, id_q, b1_q, b3_q, b2_q, b4_q, b8_new, data_rec_in[15:8], b6_q, b5_q};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            id_q   <= '0;
            b1_q   <= '0;
            b2_q   <= '0;
            b3_q   <= '0;
            b4_q   <= '0;
            b5_q   <= '0;
            b6_q   <= '0;
            b7_q   <= '0;
            b8_q   <= '0;
            open_q <= 1'b0;
        end else if (wr_en) begin
            case (addr)
                5'd5: begin
                    id_q   <= data_rec_in[15:5];
                    b1_q   <= '0;
                    b2_q   <= '0;
                    b3_q   <= '0;
                    b4_q   <= '0;
                    b5_q   <= '0;
                    b6_q   <= '0;
                    b7_q   <= '0;
                    b8_q   <= '0;
                    open_q <= 1'b1;
                end
                5'd3: begin
                    if (open_q) begin
                        b1_q <= data_rec_in[15:8];
                        b2_q <= data_rec_in[7:0];
                    end
                end
                5'd2: begin
                    if (open_q) begin
                        b3_q <= data_rec_in[15:8];
                        b4_q <= data_rec_in[7:0];
                    end
                end
                5'd1: begin
                    if (open_q) begin
                        b5_q <= data_rec_in[15:8];
                        b6_q <= data_rec_in[7:0];
                    end
                end
                5'd0: begin
                    if (open_q) begin
                        b7_q   <= data_rec_in[15:8];
                        b8_q   <= b8_new;
                        open_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        fifo_empty = (level_q == '0);
        full       = (level_q == LvlW'(DEPTH));
        pop        = !fifo_empty && msg_ready;
        // A full queue still takes the new message if the head leaves this cycle
        push       = is_close && (!full || pop);
        drop       = is_close && !push;
        level_d    = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LvlW'(1);
            2'b01:   level_d = level_q - LvlW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            level_q     <= '0;
            ovf_cnt_q   <= '0;
            ovf_pulse_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            level_q     <= level_d;
            ovf_pulse_q <= drop;
            frame_err_q <= is_orphan;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            if (drop && (ovf_cnt_q != '1)) begin
                ovf_cnt_q <= ovf_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_msg;
        end
    end

    always_comb begin
        msg_valid  = !fifo_empty;
        msg_data   = fifo_empty ? 76'h0 : mem_q[rd_ptr_q];
        fifo_level = level_q;
        fifo_full  = full;
        ovf_cnt    = ovf_cnt_q;
        ovf_pulse  = ovf_pulse_q;
        frame_err  = frame_err_q;
    end

endmodule

// File: tb/tb_can_rec_msg_fifo.sv
// Directed bench for can_rec_msg_fifo: frame assembly, restart/orphan handling,
// overflow, full push with simultaneous pop, and reset.
module tb_can_rec_msg_fifo;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic [4:0]  addr;
    logic [15:0] data_rec_in;
    logic [4:0]  can_rec_select;
    logic        debug_mode;
    logic        msg_valid;
    logic        msg_ready;
    logic [75:0] msg_data;
    logic [2:0]  fifo_level;
    logic        fifo_full;
    logic [7:0]  ovf_cnt;
    logic        ovf_pulse;
    logic        frame_err;

    int checks = 0;
    int errors = 0;

    can_rec_msg_fifo #(
        .DEPTH   (4),
        .BUS_ID_W(5),
        .CNT_W   (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .wr_en         (wr_en),
        .addr          (addr),
        .data_rec_in   (data_rec_in),
        .can_rec_select(can_rec_select),
        .debug_mode    (debug_mode),
        .msg_valid     (msg_valid),
        .msg_ready     (msg_ready),
        .msg_data      (msg_data),
        .fifo_level    (fifo_level),
        .fifo_full     (fifo_full),
        .ovf_cnt       (ovf_cnt),
        .ovf_pulse     (ovf_pulse),
        .frame_err     (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [75:0] obs, input logic [75:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one word for one clock; returns 1 time unit after the capturing edge.
    task automatic word(input logic [4:0] a, input logic [15:0] d);
        wr_en       = 1'b1;
        addr        = a;
        data_rec_in = d;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
    endtask

    task automatic idle();
        wr_en = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic pop_one();
        msg_ready = 1'b1;
        idle();
        msg_ready = 1'b0;
    endtask

    task automatic send_frame(input int k);
        logic [7:0] kb;
        kb = 8'(k);
        word(5'd5, 16'(k << 5));
        word(5'd0, {8'hA0 + kb, kb});
    endtask

    function automatic logic [75:0] frame_msg(input int k);
        logic [7:0] kb;
        kb = 8'(k);
        return {1'b0, 11'(k), 32'h0, kb, 8'hA0 + kb, 16'h0};
    endfunction

    localparam logic [75:0] ExpA    = {12'h0D3, 8'h11, 8'h33, 8'h22, 8'h44, 8'h13, 8'h77, 8'h66, 8'h55};
    localparam logic [75:0] ExpADbg = {12'h0D3, 8'h11, 8'h33, 8'h22, 8'h44, 8'hFF, 8'h77, 8'h66, 8'h55};
    localparam logic [75:0] ExpPart = {12'h7FF, 32'h0, 8'h01, 8'hAB, 16'h0};
    localparam logic [75:0] ExpRst  = {12'h001, 32'h0, 8'h13, 8'h22, 16'h0};

    initial begin
        rst            = 1'b1;
        wr_en          = 1'b0;
        addr           = '0;
        data_rec_in    = '0;
        can_rec_select = 5'h13;
        debug_mode     = 1'b0;
        msg_ready      = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        check("rst_valid", msg_valid, 0);
        check("rst_data", msg_data, 0);
        check("rst_level", fifo_level, 0);
        check("rst_full", fifo_full, 0);
        check("rst_ovf_cnt", ovf_cnt, 0);
        check("rst_ovf_pulse", ovf_pulse, 0);
        check("rst_frame_err", frame_err, 0);

        // Basic frame, bus ID in byte 8
        word(5'd5, 16'h1A60);
        word(5'd3, 16'h1122);
        word(5'd2, 16'h3344);
        word(5'd1, 16'h5566);
        check("a_not_yet_valid", msg_valid, 0);
        word(5'd0, 16'h77FF);
        check("a_valid", msg_valid, 1);
        check("a_data", msg_data, ExpA);
        check("a_level", fifo_level, 1);
        idle();
        check("a_stable", msg_data, ExpA);
        pop_one();
        check("a_popped_valid", msg_valid, 0);
        check("a_popped_data", msg_data, 0);

        // Same frame, debug byte 8
        debug_mode = 1'b1;
        word(5'd5, 16'h1A60);
        word(5'd3, 16'h1122);
        word(5'd2, 16'h3344);
        word(5'd1, 16'h5566);
        word(5'd0, 16'h77FF);
        check("a_dbg_data", msg_data, ExpADbg);
        pop_one();

        // Partial frame
        word(5'd5, 16'hFFE0);
        word(5'd0, 16'hAB01);
        check("partial_data", msg_data, ExpPart);
        pop_one();

        // Restart plus orphan close
        debug_mode = 1'b0;
        word(5'd5, 16'h1A60);
        word(5'd3, 16'h1111);
        word(5'd5, 16'h0020);
        word(5'd0, 16'h2233);
        check("restart_data", msg_data, ExpRst);
        check("restart_no_err", frame_err, 0);
        word(5'd0, 16'h4455);
        check("orphan_err", frame_err, 1);
        check("orphan_level", fifo_level, 1);
        idle();
        check("orphan_err_drop", frame_err, 0);
        pop_one();
        check("restart_empty", fifo_level, 0);

        // Fill and overflow
        debug_mode = 1'b1;
        for (int k = 1; k <= 4; k++) send_frame(k);
        check("fill_full", fifo_full, 1);
        check("fill_level", fifo_level, 4);
        check("fill_no_ovf", ovf_pulse, 0);
        send_frame(5);
        check("ovf5_pulse", ovf_pulse, 1);
        check("ovf5_cnt", ovf_cnt, 1);
        word(5'd5, 16'(6 << 5));
        check("ovf5_pulse_drop", ovf_pulse, 0);
        word(5'd0, 16'hA606);
        check("ovf6_pulse", ovf_pulse, 1);
        check("ovf6_cnt", ovf_cnt, 2);
        check("ovf_level", fifo_level, 4);
        check("ovf_head", msg_data, frame_msg(1));

        // Full push with simultaneous pop
        word(5'd5, 16'(7 << 5));
        msg_ready = 1'b1;
        word(5'd0, 16'hA707);
        msg_ready = 1'b0;
        check("fullpop_level", fifo_level, 4);
        check("fullpop_no_ovf", ovf_pulse, 0);
        check("fullpop_cnt", ovf_cnt, 2);
        check("fullpop_head", msg_data, frame_msg(2));

        msg_ready = 1'b1;
        check("drain_2", msg_data, frame_msg(2));
        idle();
        check("drain_3", msg_data, frame_msg(3));
        idle();
        check("drain_4", msg_data, frame_msg(4));
        idle();
        check("drain_7", msg_data, frame_msg(7));
        idle();
        msg_ready = 1'b0;
        check("drain_valid", msg_valid, 0);
        check("drain_level", fifo_level, 0);

        // Reset with 3 stored messages and an open frame
        for (int k = 8; k <= 10; k++) send_frame(k);
        check("pre_rst_level", fifo_level, 3);
        word(5'd5, 16'h0040);
        rst = 1'b1;
        msg_ready = 1'b1;
        word(5'd3, 16'hBEEF);
        rst = 1'b0;
        msg_ready = 1'b0;
        check("mid_rst_valid", msg_valid, 0);
        check("mid_rst_level", fifo_level, 0);
        check("mid_rst_ovf_cnt", ovf_cnt, 0);
        word(5'd0, 16'h1234);
        check("post_rst_err", frame_err, 1);
        check("post_rst_level", fifo_level, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
